// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: latches a level-held MEM-stage request,
// stalls the pipeline for LATENCY+1 cycles, then completes the access with a one-cycle done pulse.
module dmem_responder #(
  parameter int DEPTH_LOG = 10,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [15:0] wrt_data,
  output logic [15:0] rd_data,
  output logic        stall,
  output logic        done
);

  localparam int         DEPTH    = 1 << DEPTH_LOG;
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r;
  logic [7:0]           cnt_r;
  logic [DEPTH_LOG-1:0] addr_r;
  logic                 re_r;
  logic                 we_r;
  logic [15:0]          wdata_r;
  logic [15:0]          rd_data_r;
  logic [15:0]          mem_r [DEPTH];

  logic req_s;
  logic access_s;
  logic mem_wr_s;
  logic unused_addr_s;

  // Upper address bits alias onto the implemented depth.
  assign unused_addr_s = ^addr[15:DEPTH_LOG];

  // Request decode and the single cycle on which the latched access is performed.
  always_comb begin
    req_s    = re | we;
    access_s = 1'b0;
    if ((state_r == BUSY) && (cnt_r == 8'd0)) begin
      access_s = 1'b1;
    end else begin
      access_s = 1'b0;
    end
    mem_wr_s = access_s & we_r;
  end

  // Stall must be combinational so it rises in the same cycle the request appears.
  assign stall   = ~rst & req_s & (state_r != DONE);
  assign done    = (state_r == DONE);
  assign rd_data = rd_data_r;

  // Control FSM, request latch and read-data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= 8'd0;
      addr_r    <= '0;
      re_r      <= 1'b0;
      we_r      <= 1'b0;
      wdata_r   <= 16'h0000;
      rd_data_r <= 16'h0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            state_r <= BUSY;
            cnt_r   <= CNT_LOAD;
            addr_r  <= addr[DEPTH_LOG-1:0];
            re_r    <= re;
            we_r    <= we;
            wdata_r <= wrt_data;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (cnt_r != 8'd0) begin
            cnt_r <= cnt_r - 8'd1;
          end else begin
            state_r <= DONE;
            // Sampled alongside the write, so a combined access returns the old contents.
            if (re_r) begin
              rd_data_r <= mem_r[addr_r];
            end else begin
              rd_data_r <= rd_data_r;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_wr_s) begin
      mem_r[addr_r] <= wdata_r;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// accesses against an array-based memory model, for LATENCY = 4 and LATENCY = 1.
module tb_dmem_responder;

  localparam int L4 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] addr4, wd4, rd4;
  logic        re4, we4, stall4, done4;
  logic [15:0] addr1, wd1, rd1;
  logic        re1, we1, stall1, done1;

  int passed = 0;
  int total  = 0;

  logic [15:0] ref_mem [1024];
  bit          known [1024];
  logic [15:0] exp_rd4;

  dmem_responder #(.DEPTH_LOG(10), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .addr(addr4), .re(re4), .we(we4), .wrt_data(wd4),
    .rd_data(rd4), .stall(stall4), .done(done4)
  );

  dmem_responder #(.DEPTH_LOG(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .addr(addr1), .re(re1), .we(we1), .wrt_data(wd1),
    .rd_data(rd1), .stall(stall1), .done(done1)
  );

  // Drives one request on dut4 and holds it until done; a_busy replaces addr once BUSY.
  task automatic access4(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] a_busy, output int stall_n, output int done_at,
                         output logic [15:0] rdv);
    @(negedge clk);
    re4 = r; we4 = w; addr4 = a; wd4 = d;
    stall_n = 0; done_at = -1; rdv = 16'h0000;
    #1;
    for (int cyc = 0; cyc < L4 + 8; cyc++) begin
      if (stall4) stall_n++;
      if (done4) begin
        done_at = cyc;
        rdv = rd4;
        break;
      end
      @(negedge clk); #1;
      addr4 = a_busy;
    end
    re4 = 1'b0; we4 = 1'b0;
  endtask

  // Model update after a completed dut4 access.
  task automatic model_apply(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    int idx;
    idx = int'(a) % 1024;
    if (r) exp_rd4 = ref_mem[idx];
    if (w) begin
      ref_mem[idx] = d;
      known[idx] = 1'b1;
    end
  endtask

  // Write on dut1 with a bounded wait; ok reports completion.
  task automatic write1(input logic [15:0] a, input logic [15:0] d, output bit ok);
    @(negedge clk);
    we1 = 1'b1; addr1 = a; wd1 = d; ok = 1'b0;
    #1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (done1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    we1 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; re4 = 1'b1; addr4 = 16'h0005;
    repeat (2) @(negedge clk);
    #1;
    total++; if (stall4 !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall4); else passed++;
    total++; if (rd4 !== 16'h0000) $display("FAIL reset_rd got=%h exp=0000", rd4); else passed++;
    total++; if (done4 !== 1'b0) $display("FAIL reset_done got=%b exp=0", done4); else passed++;
    rst = 1'b0;
    @(negedge clk); #1;
    total++; if (stall4 !== 1'b1) $display("FAIL reset_release_stall got=%b exp=1", stall4); else passed++;
    rst = 1'b1; re4 = 1'b0;
    #1;
    total++; if (stall4 !== 1'b0) $display("FAIL reset_abort_stall got=%b exp=0", stall4); else passed++;
    @(negedge clk);
    rst = 1'b0;
    exp_rd4 = 16'h0000;
  endtask

  task automatic test_write_read;
    int s_w, d_w, s_r, d_r;
    logic [15:0] rv;
    access4(1'b0, 1'b1, 16'h0005, 16'hBEEF, 16'h0005, s_w, d_w, rv);
    total++; if (s_w != L4 + 1) $display("FAIL wr_stall_cycles got=%0d exp=%0d", s_w, L4 + 1); else passed++;
    total++; if (d_w != L4 + 1) $display("FAIL wr_done_cycle got=%0d exp=%0d", d_w, L4 + 1); else passed++;
    total++; if (rv !== exp_rd4) $display("FAIL wr_rd_hold got=%h exp=%h", rv, exp_rd4); else passed++;
    model_apply(1'b0, 1'b1, 16'h0005, 16'hBEEF);
    access4(1'b1, 1'b0, 16'h0005, 16'h0000, 16'h0005, s_r, d_r, rv);
    model_apply(1'b1, 1'b0, 16'h0005, 16'h0000);
    total++; if (rv !== 16'hBEEF) $display("FAIL rd_data got=%h exp=BEEF", rv); else passed++;
    total++; if (d_r != L4 + 1) $display("FAIL rd_done_cycle got=%0d exp=%0d", d_r, L4 + 1); else passed++;
    total++; if (s_w + s_r != 10) $display("FAIL total_stall got=%0d exp=10", s_w + s_r); else passed++;
    @(negedge clk); #1;
    total++; if (done4 !== 1'b0) $display("FAIL done_pulse_width got=%b exp=0", done4); else passed++;
    total++; if (stall4 !== 1'b0) $display("FAIL idle_stall got=%b exp=0", stall4); else passed++;
  endtask

  task automatic test_read_write_same;
    int s, d;
    logic [15:0] rv;
    access4(1'b0, 1'b1, 16'h0003, 16'h1111, 16'h0003, s, d, rv);
    model_apply(1'b0, 1'b1, 16'h0003, 16'h1111);
    access4(1'b1, 1'b1, 16'h0003, 16'h2222, 16'h0003, s, d, rv);
    model_apply(1'b1, 1'b1, 16'h0003, 16'h2222);
    total++; if (rv !== 16'h1111) $display("FAIL rw_old_data got=%h exp=1111", rv); else passed++;
    access4(1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0003, s, d, rv);
    model_apply(1'b1, 1'b0, 16'h0003, 16'h0000);
    total++; if (rv !== 16'h2222) $display("FAIL rw_new_data got=%h exp=2222", rv); else passed++;
  endtask

  task automatic test_alias;
    int s, d;
    logic [15:0] rv;
    access4(1'b0, 1'b1, 16'h0000, 16'h1234, 16'h0000, s, d, rv);
    model_apply(1'b0, 1'b1, 16'h0000, 16'h1234);
    access4(1'b0, 1'b1, 16'h0407, 16'hA5A5, 16'h0407, s, d, rv);
    model_apply(1'b0, 1'b1, 16'h0407, 16'hA5A5);
    access4(1'b1, 1'b0, 16'h0007, 16'h0000, 16'h0007, s, d, rv);
    model_apply(1'b1, 1'b0, 16'h0007, 16'h0000);
    total++; if (rv !== 16'hA5A5) $display("FAIL alias_read got=%h exp=A5A5", rv); else passed++;
    access4(1'b1, 1'b0, 16'h0007, 16'h0000, 16'h0000, s, d, rv);
    model_apply(1'b1, 1'b0, 16'h0007, 16'h0000);
    total++; if (rv !== 16'hA5A5) $display("FAIL addr_change_immunity got=%h exp=A5A5", rv); else passed++;
  endtask

  task automatic test_reset_mid_write;
    int s, d;
    logic [15:0] rv;
    access4(1'b0, 1'b1, 16'h0009, 16'h0F0F, 16'h0009, s, d, rv);
    model_apply(1'b0, 1'b1, 16'h0009, 16'h0F0F);
    @(negedge clk);
    we4 = 1'b1; addr4 = 16'h0009; wd4 = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (stall4 !== 1'b0) $display("FAIL midrst_stall got=%b exp=0", stall4); else passed++;
    total++; if (rd4 !== 16'h0000) $display("FAIL midrst_rd got=%h exp=0000", rd4); else passed++;
    @(negedge clk);
    we4 = 1'b0; rst = 1'b0;
    exp_rd4 = 16'h0000;
    access4(1'b1, 1'b0, 16'h0009, 16'h0000, 16'h0009, s, d, rv);
    model_apply(1'b1, 1'b0, 16'h0009, 16'h0000);
    total++; if (rv !== 16'h0F0F) $display("FAIL midrst_write_dropped got=%h exp=0F0F", rv); else passed++;
  endtask

  task automatic test_random;
    int s, d, idx, op;
    logic [15:0] a, wd, rv, exp;
    logic r, w;
    for (int i = 0; i < 30; i++) begin
      a   = 16'($urandom_range(0, 15)) | (16'($urandom_range(0, 63)) << 10);
      wd  = 16'($urandom);
      idx = int'(a) % 1024;
      op  = known[idx] ? int'($urandom_range(0, 2)) : 0;
      w   = (op != 1);
      r   = (op != 0);
      exp = r ? ref_mem[idx] : exp_rd4;
      access4(r, w, a, wd, 16'($urandom), s, d, rv);
      model_apply(r, w, a, wd);
      total++; if (s != L4 + 1) $display("FAIL rand_stall[%0d] got=%0d exp=%0d", i, s, L4 + 1); else passed++;
      total++; if (d != L4 + 1) $display("FAIL rand_done[%0d] got=%0d exp=%0d", i, d, L4 + 1); else passed++;
      total++; if (rv !== exp) $display("FAIL rand_rd[%0d] op=%0d addr=%h got=%h exp=%h", i, op, a, rv, exp); else passed++;
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [5:0] stall_pat, done_pat;
    logic [15:0] rv_a, rv_b;
    write1(16'h0001, 16'h1357, ok);
    total++; if (!ok) $display("FAIL lat1_write_a got=timeout exp=done"); else passed++;
    write1(16'h0002, 16'h2468, ok);
    total++; if (!ok) $display("FAIL lat1_write_b got=timeout exp=done"); else passed++;
    @(negedge clk);
    re1 = 1'b1; addr1 = 16'h0001;
    stall_pat = 6'b0; done_pat = 6'b0; rv_a = 16'h0000; rv_b = 16'h0000;
    #1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      stall_pat = {stall_pat[4:0], stall1};
      done_pat  = {done_pat[4:0], done1};
      if (cyc == 2) begin
        rv_a = rd1;
        addr1 = 16'h0002;
      end
      if (cyc == 5) rv_b = rd1;
      if (cyc < 5) begin
        @(negedge clk); #1;
      end
    end
    re1 = 1'b0;
    total++; if (stall_pat !== 6'b110110) $display("FAIL lat1_stall_pattern got=%b exp=110110", stall_pat); else passed++;
    total++; if (done_pat !== 6'b001001) $display("FAIL lat1_done_pattern got=%b exp=001001", done_pat); else passed++;
    total++; if (rv_a !== 16'h1357) $display("FAIL lat1_rd_first got=%h exp=1357", rv_a); else passed++;
    total++; if (rv_b !== 16'h2468) $display("FAIL lat1_rd_second got=%h exp=2468", rv_b); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    re4 = 1'b0; we4 = 1'b0; addr4 = 16'h0000; wd4 = 16'h0000;
    re1 = 1'b0; we1 = 1'b0; addr1 = 16'h0000; wd1 = 16'h0000;
    exp_rd4 = 16'h0000;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = 16'h0000;
      known[i] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_read_write_same();
    test_alias();
    test_reset_mid_write();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
